sdiv_seq: RTL and testbench

Sequencer that sits directly upstream of the team's iterative unsigned divider and turns CPU divide requests into complete results. It supports three ops: unsigned um/mod, symmetric signed sm/rem, and floored signed fm/mod. For signed ops it converts operands to magnitudes, launches the divider, waits for completion, then applies sign and floor correction and signed overflow checks. Results go back over a valid/ready response port to the chad ALU/stack unit.

---
 rtl/sdiv_seq.sv | 232 +++++++++++++++++++++++
 tb/tb_sdiv_seq.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdiv_seq.sv
// Signed/unsigned divide sequencer wrapped around an external iterative unsigned divider.
// Latency: accept->rsp_valid is WIDTH+4 cycles normally, 4 on divider overflow, 1 on divide by zero.
// Backpressure: one request in flight; req_ready only in IDLE, rsp_* held stable until rsp_ready.
//
// Optional feature: define SDIV_FLOORED_EN to make op 10 perform floored fm/mod;
// without it op 10 behaves exactly like symmetric sm/rem.
module sdiv_seq #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               arstn,
    // request port
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [1:0]         req_op,
    input  logic [2*WIDTH-1:0] req_num,
    input  logic [WIDTH-1:0]   req_den,
    // response port
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [WIDTH-1:0]   rsp_quot,
    output logic [WIDTH-1:0]   rsp_rem,
    output logic               rsp_ovf,
    output logic               rsp_dz,
    // divider port
    output logic               div_go,
    output logic [2*WIDTH-1:0] div_dividend,
    output logic [WIDTH-1:0]   div_divisor,
    input  logic               div_busy,
    input  logic [WIDTH-1:0]   div_quot,
    input  logic [WIDTH-1:0]   div_rem,
    input  logic               div_ovf
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_FIX,
        S_RESP
    } state_t;

    // Largest positive quotient magnitude and largest negative quotient magnitude,
    // held one bit wider than a cell so a floor increment cannot wrap.
    localparam logic [WIDTH:0] Q_POS_MAX = {2'b00, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH:0] Q_NEG_MAX = {2'b01, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH:0] Q_ONE     = {{WIDTH{1'b0}}, 1'b1};

    state_t               state_q,        state_d;
    logic                 signed_q,       signed_d;
    logic                 sign_n_q,       sign_n_d;
    logic                 sign_d_q,       sign_d_d;
    logic                 div_go_q,       div_go_d;
    logic [2*WIDTH-1:0]   div_dividend_q, div_dividend_d;
    logic [WIDTH-1:0]     div_divisor_q,  div_divisor_d;
    logic                 rsp_valid_q,    rsp_valid_d;
    logic [WIDTH-1:0]     rsp_quot_q,     rsp_quot_d;
    logic [WIDTH-1:0]     rsp_rem_q,      rsp_rem_d;
    logic                 rsp_ovf_q,      rsp_ovf_d;
    logic                 rsp_dz_q,       rsp_dz_d;
`ifdef SDIV_FLOORED_EN
    logic                 floor_q,        floor_d;
`endif

    // Request decode: op 11 falls back to unsigned, signs only matter for signed ops.
    logic                 req_signed;
    logic                 req_sign_n;
    logic                 req_sign_d;
    logic [2*WIDTH-1:0]   req_num_mag;
    logic [WIDTH-1:0]     req_den_mag;
`ifdef SDIV_FLOORED_EN
    logic                 req_floor;
    assign req_floor   = (req_op == 2'b10);
`endif
    assign req_signed  = (req_op == 2'b01) || (req_op == 2'b10);
    assign req_sign_n  = req_signed & req_num[2*WIDTH-1];
    assign req_sign_d  = req_signed & req_den[WIDTH-1];
    // The most negative divisor negates to itself, which read unsigned is 2^(WIDTH-1).
    assign req_num_mag = req_sign_n ? -req_num : req_num;
    assign req_den_mag = req_sign_d ? -req_den : req_den;

    // Sign/floor correction of the divider magnitudes, consumed in FIX.
    logic                 fix_qneg;
    logic                 fix_rneg;
    logic [WIDTH:0]       fix_qmag;
    logic [WIDTH-1:0]     fix_rmag;
    logic [WIDTH:0]       fix_qres;
    logic [WIDTH-1:0]     fix_rres;
    logic                 fix_range_ovf;
    logic                 fix_ovf;

    // Apply quotient/remainder signs, optional floor adjust and signed range checks.
    always_comb begin
        fix_qneg = sign_n_q ^ sign_d_q;
        fix_rneg = sign_n_q;
        fix_qmag = {1'b0, div_quot};
        fix_rmag = div_rem;
`ifdef SDIV_FLOORED_EN
        if (floor_q) begin
            // Floored remainder follows the divisor sign; a non-zero remainder with a
            // negative quotient pushes the quotient one step further from zero.
            fix_rneg = sign_d_q;
            if (fix_qneg && (fix_rmag != '0)) begin
                fix_qmag = fix_qmag + Q_ONE;
                fix_rmag = div_divisor_q - fix_rmag;
            end
        end
`endif
        fix_qres = fix_qneg ? -fix_qmag : fix_qmag;
        fix_rres = fix_rneg ? -fix_rmag : fix_rmag;
        fix_range_ovf = fix_qneg ? (fix_qmag > Q_NEG_MAX) : (fix_qmag > Q_POS_MAX);
        fix_ovf = div_ovf | (signed_q & fix_range_ovf);
    end

    // Next-state and next-output computation for the sequencer.
    always_comb begin
        state_d        = state_q;
        signed_d       = signed_q;
        sign_n_d       = sign_n_q;
        sign_d_d       = sign_d_q;
        div_go_d       = 1'b0;
        div_dividend_d = div_dividend_q;
        div_divisor_d  = div_divisor_q;
        rsp_valid_d    = rsp_valid_q;
        rsp_quot_d     = rsp_quot_q;
        rsp_rem_d      = rsp_rem_q;
        rsp_ovf_d      = rsp_ovf_q;
        rsp_dz_d       = rsp_dz_q;
`ifdef SDIV_FLOORED_EN
        floor_d        = floor_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    signed_d       = req_signed;
                    sign_n_d       = req_sign_n;
                    sign_d_d       = req_sign_d;
`ifdef SDIV_FLOORED_EN
                    floor_d        = req_floor;
`endif
                    div_dividend_d = req_num_mag;
                    div_divisor_d  = req_den_mag;
                    if (req_den == '0) begin
                        // Divide by zero never reaches the divider.
                        rsp_quot_d  = '1;
                        rsp_rem_d   = '1;
                        rsp_ovf_d   = 1'b1;
                        rsp_dz_d    = 1'b1;
                        rsp_valid_d = 1'b1;
                        state_d     = S_RESP;
                    end else begin
                        div_go_d = 1'b1;
                        state_d  = S_LAUNCH;
                    end
                end
            end
            S_LAUNCH: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!div_busy) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                rsp_quot_d  = fix_ovf ? '1 : fix_qres[WIDTH-1:0];
                rsp_rem_d   = fix_ovf ? '1 : fix_rres;
                rsp_ovf_d   = fix_ovf;
                rsp_dz_d    = 1'b0;
                rsp_valid_d = 1'b1;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Sequencer state and registered outputs; reset discards anything in flight.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q        <= S_IDLE;
            signed_q       <= 1'b0;
            sign_n_q       <= 1'b0;
            sign_d_q       <= 1'b0;
            div_go_q       <= 1'b0;
            div_dividend_q <= '0;
            div_divisor_q  <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_quot_q     <= '0;
            rsp_rem_q      <= '0;
            rsp_ovf_q      <= 1'b0;
            rsp_dz_q       <= 1'b0;
`ifdef SDIV_FLOORED_EN
            floor_q        <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            signed_q       <= signed_d;
            sign_n_q       <= sign_n_d;
            sign_d_q       <= sign_d_d;
            div_go_q       <= div_go_d;
            div_dividend_q <= div_dividend_d;
            div_divisor_q  <= div_divisor_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_quot_q     <= rsp_quot_d;
            rsp_rem_q      <= rsp_rem_d;
            rsp_ovf_q      <= rsp_ovf_d;
            rsp_dz_q       <= rsp_dz_d;
`ifdef SDIV_FLOORED_EN
            floor_q        <= floor_d;
`endif
        end
    end

    assign req_ready    = (state_q == S_IDLE);
    assign rsp_valid    = rsp_valid_q;
    assign rsp_quot     = rsp_quot_q;
    assign rsp_rem      = rsp_rem_q;
    assign rsp_ovf      = rsp_ovf_q;
    assign rsp_dz       = rsp_dz_q;
    assign div_go       = div_go_q;
    assign div_dividend = div_dividend_q;
    assign div_divisor  = div_divisor_q;

endmodule

// File: tb/tb_sdiv_seq.sv
// Directed bench for sdiv_seq with a behavioural 16-cycle iterative divider.
// Latency: measured from the accept edge to the first cycle with rsp_valid.
// Backpressure: exercised by holding rsp_ready low while a result is pending.
module tb_sdiv_seq;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           arstn;
    logic           req_valid, req_ready;
    logic [1:0]     req_op;
    logic [2*W-1:0] req_num;
    logic [W-1:0]   req_den;
    logic           rsp_valid, rsp_ready;
    logic [W-1:0]   rsp_quot, rsp_rem;
    logic           rsp_ovf, rsp_dz;
    logic           div_go;
    logic [2*W-1:0] div_dividend;
    logic [W-1:0]   div_divisor;
    logic           div_busy;
    logic [W-1:0]   div_quot, div_rem;
    logic           div_ovf;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int go_cnt   = 0;

    always #5 clk = ~clk;

    sdiv_seq #(.WIDTH(W)) dut (
        .clk(clk), .arstn(arstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_num(req_num), .req_den(req_den),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_quot(rsp_quot),
        .rsp_rem(rsp_rem), .rsp_ovf(rsp_ovf), .rsp_dz(rsp_dz),
        .div_go(div_go), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_busy(div_busy), .div_quot(div_quot), .div_rem(div_rem), .div_ovf(div_ovf)
    );

    // Behavioural divider: busy for W cycles after go, immediate return on overflow.
    logic [2*W-1:0] m_q_full, m_r_full;
    int             m_cnt;
    assign m_q_full = div_dividend / {{W{1'b0}}, div_divisor};
    assign m_r_full = div_dividend % {{W{1'b0}}, div_divisor};

    always @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            div_busy <= 1'b0; div_ovf <= 1'b0; div_quot <= '0; div_rem <= '0; m_cnt <= 0;
        end else if (div_go) begin
            if (div_dividend[2*W-1:W] >= div_divisor) begin
                div_ovf <= 1'b1; div_busy <= 1'b0; div_quot <= '1; div_rem <= '1;
            end else begin
                div_ovf <= 1'b0; div_busy <= 1'b1; m_cnt <= W;
                div_quot <= m_q_full[W-1:0]; div_rem <= m_r_full[W-1:0];
            end
        end else if (div_busy) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) div_busy <= 1'b0;
        end
    end

    always @(posedge clk) if (arstn && div_go) go_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    // Present one request, return after the accept edge with the cycles until rsp_valid.
    task automatic issue(input logic [1:0] op, input logic [2*W-1:0] num,
                         input logic [W-1:0] den, output int lat);
        @(negedge clk);
        req_op = op; req_num = num; req_den = den; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 200);
    endtask

    // Accept the pending response; returns at the negedge of the following cycle.
    task automatic consume();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        arstn = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_num = '0; req_den = '0; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        arstn = 1'b1;
        @(negedge clk);
        chk_cnt++;
        if ({req_ready, rsp_valid, rsp_ovf, rsp_dz, div_go} !== 5'b10000)
            $display("FAIL reset_ctrl: got %b required 10000", {req_ready, rsp_valid, rsp_ovf, rsp_dz, div_go});
        else pass_cnt++;
        chk_cnt++;
        if ({rsp_quot, rsp_rem, div_dividend, div_divisor} !== 80'h0)
            $display("FAIL reset_data: got %h required 0", {rsp_quot, rsp_rem, div_dividend, div_divisor});
        else pass_cnt++;
    endtask

    task automatic test_unsigned();
        int lat, g0;
        g0 = go_cnt;
        issue(2'b00, 32'h0001_0005, 16'h0003, lat);
        chk_cnt++;
        if ({rsp_quot, rsp_rem, rsp_ovf, rsp_dz} !== {16'h5557, 16'h0000, 2'b00})
            $display("FAIL um_result: got %h/%h ovf=%b dz=%b required 5557/0000 0 0", rsp_quot, rsp_rem, rsp_ovf, rsp_dz);
        else pass_cnt++;
        chk_cnt++;
        if (lat !== 20) $display("FAIL um_latency: got %0d required 20", lat);
        else pass_cnt++;
        chk_cnt++;
        if (go_cnt - g0 !== 1) $display("FAIL um_go_pulses: got %0d required 1", go_cnt - g0);
        else pass_cnt++;
        consume();
        // op 11 falls back to unsigned: 0xFFFE read unsigned exceeds the dividend.
        issue(2'b11, 32'h0000_FFF9, 16'hFFFE, lat);
        chk_cnt++;
        if ({rsp_quot, rsp_rem, rsp_ovf} !== {16'h0000, 16'hFFF9, 1'b0})
            $display("FAIL op11_unsigned: got %h/%h ovf=%b required 0000/fff9 0", rsp_quot, rsp_rem, rsp_ovf);
        else pass_cnt++;
        consume();
    endtask

    task automatic test_signed();
        int lat;
        issue(2'b01, 32'hFFFF_FFF9, 16'h0002, lat);
        chk_cnt++;
        if ({rsp_quot, rsp_rem, rsp_ovf, rsp_dz} !== {16'hFFFD, 16'hFFFF, 2'b00})
            $display("FAIL sm_neg7_by2: got %h/%h ovf=%b dz=%b required fffd/ffff 0 0", rsp_quot, rsp_rem, rsp_ovf, rsp_dz);
        else pass_cnt++;
        chk_cnt++;
        if ({div_dividend, div_divisor} !== {32'h0000_0007, 16'h0002})
            $display("FAIL sm_magnitudes: got %h/%h required 00000007/0002", div_dividend, div_divisor);
        else pass_cnt++;
        consume();
        // Most negative divisor: magnitude 0x8000, remainder keeps dividend sign.
        issue(2'b01, 32'h0000_0007, 16'h8000, lat);
        chk_cnt++;
        if ({rsp_quot, rsp_rem, rsp_ovf, div_divisor} !== {16'h0000, 16'h0007, 1'b0, 16'h8000})
            $display("FAIL sm_minden: got %h/%h ovf=%b dsr=%h required 0000/0007 0 8000", rsp_quot, rsp_rem, rsp_ovf, div_divisor);
        else pass_cnt++;
        consume();
    endtask

    task automatic test_floored();
        int lat;
        logic [W-1:0] eq1, er1, eq2, er2;
`ifdef SDIV_FLOORED_EN
        eq1 = 16'hFFFC; er1 = 16'h0001; eq2 = 16'hFFFF; er2 = 16'h8007;
`else
        eq1 = 16'hFFFD; er1 = 16'hFFFF; eq2 = 16'h0000; er2 = 16'h0007;
`endif
        issue(2'b10, 32'hFFFF_FFF9, 16'h0002, lat);
        chk_cnt++;
        if ({rsp_quot, rsp_rem, rsp_ovf} !== {eq1, er1, 1'b0})
            $display("FAIL fm_neg7_by2: got %h/%h ovf=%b required %h/%h 0", rsp_quot, rsp_rem, rsp_ovf, eq1, er1);
        else pass_cnt++;
        consume();
        issue(2'b10, 32'h0000_0007, 16'h8000, lat);
        chk_cnt++;
        if ({rsp_quot, rsp_rem, rsp_ovf} !== {eq2, er2, 1'b0})
            $display("FAIL fm_minden: got %h/%h ovf=%b required %h/%h 0", rsp_quot, rsp_rem, rsp_ovf, eq2, er2);
        else pass_cnt++;
        consume();
    endtask

    task automatic test_div_zero();
        int lat, g0;
        for (int op = 0; op < 4; op++) begin
            g0 = go_cnt;
            issue(op[1:0], 32'h1234_5678, 16'h0000, lat);
            chk_cnt++;
            if ({rsp_quot, rsp_rem, rsp_ovf, rsp_dz} !== {16'hFFFF, 16'hFFFF, 2'b11} || lat !== 1)
                $display("FAIL dz_op%0d: got %h/%h ovf=%b dz=%b lat=%0d required ffff/ffff 1 1 lat=1",
                         op, rsp_quot, rsp_rem, rsp_ovf, rsp_dz, lat);
            else pass_cnt++;
            consume();
            chk_cnt++;
            if (go_cnt !== g0) $display("FAIL dz_no_go_op%0d: got %0d pulses required 0", op, go_cnt - g0);
            else pass_cnt++;
        end
    endtask

    task automatic test_overflow();
        int lat;
        issue(2'b01, 32'h0000_8000, 16'h0001, lat);
        chk_cnt++;
        if ({rsp_quot, rsp_rem, rsp_ovf, rsp_dz} !== {16'hFFFF, 16'hFFFF, 2'b10})
            $display("FAIL sm_pos_ovf: got %h/%h ovf=%b dz=%b required ffff/ffff 1 0", rsp_quot, rsp_rem, rsp_ovf, rsp_dz);
        else pass_cnt++;
        consume();
        issue(2'b01, 32'hFFFF_8000, 16'h0001, lat);
        chk_cnt++;
        if ({rsp_quot, rsp_rem, rsp_ovf, rsp_dz} !== {16'h8000, 16'h0000, 2'b00})
            $display("FAIL sm_neg_edge: got %h/%h ovf=%b dz=%b required 8000/0000 0 0", rsp_quot, rsp_rem, rsp_ovf, rsp_dz);
        else pass_cnt++;
        consume();
        issue(2'b00, 32'h0005_0000, 16'h0005, lat);
        chk_cnt++;
        if ({rsp_quot, rsp_rem, rsp_ovf, rsp_dz} !== {16'hFFFF, 16'hFFFF, 2'b10} || lat !== 4)
            $display("FAIL um_div_ovf: got %h/%h ovf=%b dz=%b lat=%0d required ffff/ffff 1 0 lat=4",
                     rsp_quot, rsp_rem, rsp_ovf, rsp_dz, lat);
        else pass_cnt++;
        consume();
    endtask

    task automatic test_backpressure();
        int lat, g0;
        issue(2'b01, 32'hFFFF_FFF9, 16'h0002, lat);
        g0 = go_cnt;
        // A competing request must not be taken while the response waits.
        req_op = 2'b00; req_num = 32'h0000_0009; req_den = 16'h0003; req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk_cnt++;
            if ({rsp_valid, req_ready, rsp_quot, rsp_rem, rsp_ovf, rsp_dz} !== {2'b10, 16'hFFFD, 16'hFFFF, 2'b00})
                $display("FAIL hold_cycle%0d: got v=%b rdy=%b %h/%h required v=1 rdy=0 fffd/ffff", i,
                         rsp_valid, req_ready, rsp_quot, rsp_rem);
            else pass_cnt++;
        end
        req_valid = 1'b0;
        chk_cnt++;
        if (go_cnt !== g0) $display("FAIL hold_no_accept: got %0d launches required 0", go_cnt - g0);
        else pass_cnt++;
        consume();
    endtask

    task automatic test_back_to_back();
        int lat;
        issue(2'b00, 32'h0000_0064, 16'h0007, lat);
        consume();
        chk_cnt++;
        if ({req_ready, rsp_valid} !== 2'b10)
            $display("FAIL b2b_ready: got rdy=%b v=%b required rdy=1 v=0", req_ready, rsp_valid);
        else pass_cnt++;
        // Drive the next request in this same cycle.
        req_op = 2'b01; req_num = 32'hFFFF_FF9C; req_den = 16'h0007; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 200);
        chk_cnt++;
        if ({rsp_quot, rsp_rem, rsp_ovf} !== {16'hFFF2, 16'hFFFE, 1'b0} || lat !== 20)
            $display("FAIL b2b_second: got %h/%h ovf=%b lat=%0d required fff2/fffe 0 lat=20", rsp_quot, rsp_rem, rsp_ovf, lat);
        else pass_cnt++;
        consume();
    endtask

    task automatic test_reset_mid();
        int lat;
        @(negedge clk);
        req_op = 2'b00; req_num = 32'h0000_1000; req_den = 16'h0010; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (6) @(negedge clk);
        arstn = 1'b0;
        #2;
        chk_cnt++;
        if ({req_ready, rsp_valid, div_go, rsp_quot} !== {3'b100, 16'h0000})
            $display("FAIL midrst_state: got rdy=%b v=%b go=%b q=%h required 1 0 0 0000", req_ready, rsp_valid, div_go, rsp_quot);
        else pass_cnt++;
        #1 arstn = 1'b1;
        issue(2'b00, 32'h0001_0005, 16'h0003, lat);
        chk_cnt++;
        if ({rsp_quot, rsp_rem, rsp_ovf} !== {16'h5557, 16'h0000, 1'b0} || lat !== 20)
            $display("FAIL midrst_recover: got %h/%h ovf=%b lat=%0d required 5557/0000 0 lat=20", rsp_quot, rsp_rem, rsp_ovf, lat);
        else pass_cnt++;
        consume();
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_floored();
        test_div_zero();
        test_overflow();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
